// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// fetch_stage: owns the PC, issues one instruction-memory request at a time and
// fills the IF/ID register, honouring decode stalls and branch redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instruction,
  output logic [2:0]  encoding,
  output logic [31:0] pc,
  output logic        valid
);

  // encoding_type values
  localparam logic [2:0] ENC_R = 3'd0;
  localparam logic [2:0] ENC_I = 3'd1;
  localparam logic [2:0] ENC_S = 3'd2;
  localparam logic [2:0] ENC_B = 3'd3;
  localparam logic [2:0] ENC_U = 3'd4;
  localparam logic [2:0] ENC_J = 3'd5;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] hold_word;
  logic        discard;

  logic [31:0] redirect_pc;
  logic [31:0] load_word;

  function automatic logic [2:0] decode_enc(input logic [6:0] op);
    case (op)
      7'b0110011:                         decode_enc = ENC_R;
      7'b0010011, 7'b0000011, 7'b1100111: decode_enc = ENC_I;
      7'b0100011:                         decode_enc = ENC_S;
      7'b1100011:                         decode_enc = ENC_B;
      7'b0110111, 7'b0010111:             decode_enc = ENC_U;
      7'b1101111:                         decode_enc = ENC_J;
      default:                            decode_enc = ENC_R;
    endcase
  endfunction

  assign redirect_pc = branch_target & ~32'h0000_0003;
  assign load_word   = (state == S_HOLD) ? hold_word : imem_rdata;
  assign imem_req    = (state == S_FETCH) && !rst;
  assign imem_addr   = imem_req ? pc_q : 32'h0000_0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      pc_q        <= RESET_PC;
      discard     <= 1'b0;
      hold_word   <= 32'h0000_0000;
      valid       <= 1'b0;
      instruction <= 32'h0000_0013;
      pc          <= 32'h0000_0000;
      encoding    <= ENC_I;
    end else begin
      // Unstalled decode consumes the current word; a capture below overrides.
      if (!stall)
        valid <= 1'b0;

      if (branch_taken) begin
        pc_q  <= redirect_pc;
        valid <= 1'b0;
        case (state)
          S_FETCH: begin
            discard <= 1'b1;
            state   <= S_WAIT;
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              discard <= 1'b0;
              state   <= S_FETCH;
            end else begin
              discard <= 1'b1;
            end
          end
          default: state <= S_FETCH;
        endcase
      end else begin
        case (state)
          S_FETCH: state <= S_WAIT;
          S_WAIT: begin
            if (imem_rvalid) begin
              if (discard) begin
                discard <= 1'b0;
                state   <= S_FETCH;
              end else if (!stall) begin
                valid       <= 1'b1;
                instruction <= load_word;
                encoding    <= decode_enc(load_word[6:0]);
                pc          <= pc_q;
                pc_q        <= pc_q + 32'd4;
                state       <= S_FETCH;
              end else begin
                hold_word <= imem_rdata;
                state     <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!stall) begin
              valid       <= 1'b1;
              instruction <= load_word;
              encoding    <= decode_enc(load_word[6:0]);
              pc          <= pc_q;
              pc_q        <= pc_q + 32'd4;
              state       <= S_FETCH;
            end
          end
          default: state <= S_FETCH;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// Randomized scoreboard bench for fetch_stage: memory model with random latency,
// random stalls, redirects and resets; expected stream derived from PC rules.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;
  localparam logic [2:0] ENC_R = 3'd0, ENC_I = 3'd1, ENC_S = 3'd2,
                         ENC_B = 3'd3, ENC_U = 3'd4, ENC_J = 3'd5;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_rvalid, stall, branch_taken, valid;
  logic [31:0] imem_addr, imem_rdata, branch_target, instruction, pc;
  logic [2:0]  encoding;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instruction(instruction), .encoding(encoding), .pc(pc), .valid(valid)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        q[$];
  logic [31:0] tail_pc;
  int          total = 0;
  int          bad = 0;
  bit          flush_pending = 0;
  logic [31:0] flush_target;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  op;
    h = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    h = h ^ (h >> 15);
    case (h[3:0])
      4'd0:  op = 7'b0110011;
      4'd1:  op = 7'b0010011;
      4'd2:  op = 7'b0000011;
      4'd3:  op = 7'b1100111;
      4'd4:  op = 7'b0100011;
      4'd5:  op = 7'b1100011;
      4'd6:  op = 7'b0110111;
      4'd7:  op = 7'b0010111;
      4'd8:  op = 7'b1101111;
      4'd9:  op = 7'b0001111;
      4'd10: op = 7'b1110011;
      4'd11: op = 7'b0000000;
      4'd12: op = 7'b0110011;
      4'd13: op = 7'b0010011;
      4'd14: op = 7'b1100011;
      default: op = 7'b1111111;
    endcase
    return {h[31:7], op};
  endfunction

  function automatic logic [2:0] enc_of(input logic [6:0] op);
    case (op)
      7'b0110011:                         return ENC_R;
      7'b0010011, 7'b0000011, 7'b1100111: return ENC_I;
      7'b0100011:                         return ENC_S;
      7'b1100011:                         return ENC_B;
      7'b0110111, 7'b0010111:             return ENC_U;
      7'b1101111:                         return ENC_J;
      default:                            return ENC_R;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_seq();
    while (q.size() < 8) begin
      q.push_back('{tail_pc, mem_word(tail_pc)});
      tail_pc = tail_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] start);
    q.delete();
    tail_pc = start;
    push_seq();
  endtask

  // Instruction memory: one outstanding request, latency 1..4, drops on reset.
  int          mcnt = 0;
  logic [31:0] maddr = '0;
  bit          mrst_prev = 0;
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mcnt = 0;
      end else if (imem_req) begin
        check("mem_overlap", (mcnt != 0) ? 32'd1 : 32'd0, 32'd0);
        maddr = imem_addr;
        mcnt  = $urandom_range(1, 4);
      end
      mrst_prev = rst;
      @(posedge clk);
      #2;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (mrst_prev && !rst) begin
        // stale late response right after reset must be ignored
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_006F;
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(maddr);
        end
      end
    end
  end

  // Monitor: protocol, reset, hold and redirect checks plus scoreboard pops.
  logic        p_req = 0, p_rst = 0, p_branch = 0, p_stall = 0, p_valid = 0;
  logic [31:0] p_instr = '0, p_pc = '0;
  logic [2:0]  p_enc = '0;
  int          idle = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("req_in_reset", imem_req, 0);
      end else begin
        check("req_back_to_back", imem_req && p_req, 0);
        if (!imem_req) check("addr_idle", imem_addr, 0);
        if (p_rst) begin
          check("first_req", imem_req, 1);
          check("first_addr", imem_addr, RESET_PC);
        end
      end
      if (p_rst) begin
        check("rst_valid", valid, 0);
        check("rst_instr", instruction, 32'h0000_0013);
        check("rst_pc", pc, 0);
        check("rst_enc", encoding, ENC_I);
      end else if (p_branch) begin
        check("valid_after_branch", valid, 0);
      end else if (p_stall) begin
        check("hold_valid", valid, p_valid);
        check("hold_instr", instruction, p_instr);
        check("hold_pc", pc, p_pc);
        check("hold_enc", encoding, p_enc);
      end
      if (valid && !stall && !rst) begin
        idle = 0;
        if (q.size() == 0) begin
          check("queue_empty", 1, 0);
        end else begin
          e = q.pop_front();
          check("pc", pc, e.pc);
          check("instr", instruction, e.ins);
          check("enc", encoding, enc_of(e.ins[6:0]));
        end
      end else begin
        idle++;
        if (idle >= 200) begin
          check("progress_timeout", idle, 0);
          idle = 0;
        end
      end
      p_req = imem_req; p_rst = rst; p_branch = branch_taken; p_stall = stall;
      p_valid = valid; p_instr = instruction; p_pc = pc; p_enc = encoding;
    end
  end

  // Driver
  initial begin
    logic [31:0] t;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    restart(RESET_PC);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      branch_taken = 1'b0;
      if (flush_pending) begin
        restart(flush_target);
        flush_pending = 0;
      end
      push_seq();
      if ($urandom_range(0, 399) == 0) begin
        rst   = 1'b1;
        stall = 1'($urandom_range(0, 1));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        stall = 1'b0;
        restart(RESET_PC);
      end else begin
        stall = ($urandom_range(0, 99) < 30);
        if ($urandom_range(0, 99) < 6) begin
          if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
          else t = $urandom;
          branch_target = t;
          branch_taken  = 1'b1;
          flush_pending = 1;
          flush_target  = t & ~32'h0000_0003;
        end
      end
    end
    @(posedge clk);
    #1 branch_taken = 1'b0;
    stall = 1'b0;
    if (flush_pending) begin
      restart(flush_target);
      flush_pending = 0;
    end
    repeat (20) begin
      @(posedge clk);
      #1 push_seq();
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly upstream of decode. It owns the program counter and issues one request at a time to instruction memory. It holds the returned word in the IF/ID pipeline register as `instruction`, `encoding` and `pc` for decode. It also accepts stall from hazard logic and branch redirects (decode's `pc_branch`), flushing any wrong-path instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be word aligned.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `imem_req` out 1: request strobe, high for exactly one cycle per request.
- `imem_addr` out 32: request address. Equals the PC register while `imem_req`=1, otherwise 0.
- `imem_rvalid` in 1: response valid. Arrives L≥1 cycles after `imem_req`. At most one response is outstanding.
- `imem_rdata` in 32: response data, valid only with `imem_rvalid`.
- `stall` in 1: decode cannot accept. The IF/ID register holds its contents.
- `branch_taken` in 1: redirect strobe.
- `branch_target` in 32: redirect PC. Bits [1:0] are forced to 0.
- `instruction` out 32 (`instruction_type`): IF/ID instruction.
- `encoding` out `encoding_type`: format of `instruction`.
- `pc` out 32: address of `instruction`.
- `valid` out 1: IF/ID holds a live instruction.

## Operation
- Internal state: PC register `pc_q`, FSM, 1-entry hold buffer, `discard` flag.
- FSM states:
  - FETCH: drive `imem_req`=1 with `imem_addr`=`pc_q`, then go to WAIT.
  - WAIT: wait for `imem_rvalid`.
    - If `discard`=1: drop the word, clear `discard`, go to FETCH.
    - Else if `stall`=0: load the word into IF/ID with `valid`=1 and `pc`=`pc_q`, set `pc_q`+=4, go to FETCH.
    - Else (`stall`=1): store the word in the hold buffer, go to HOLD.
  - HOLD: when `stall`=0, move the buffer into IF/ID, set `pc_q`+=4, go to FETCH.
- IF/ID register:
  - When `stall`=0 and no word is delivered this cycle: `valid`←0; `instruction`, `pc` and `encoding` keep their last values.
  - When `stall`=1: all IF/ID outputs hold.
- Redirect (`branch_taken`=1) has priority over `stall` and responses:
  - `pc_q`←{`branch_target`[31:2],2'b00}, and `valid`←0 in the same edge.
  - In FETCH: the request issued this cycle is stale. Set `discard`=1 and go to WAIT.
  - In WAIT without `imem_rvalid`: set `discard`=1 and stay in WAIT.
  - In WAIT with `imem_rvalid` this cycle: drop the word and go to FETCH.
  - In HOLD: drop the buffer and go to FETCH.
- `imem_rvalid` outside WAIT is ignored.
- `encoding` is decoded from `imem_rdata[6:0]` when the word is captured:
  - 0110011 → R_TYPE.
  - 0010011, 0000011, 1100111 → I_TYPE.
  - 0100011 → S_TYPE.
  - 1100011 → B_TYPE.
  - 0110111, 0010111 → U_TYPE.
  - 1101111 → J_TYPE.
  - Any other opcode → R_TYPE.
- `pc_q`+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- Reset values:
  - `pc_q`=`RESET_PC`; FSM=FETCH; `discard`=0.
  - `valid`=0, `instruction`=32'h0000_0013 (NOP), `pc`=0, `encoding`=I_TYPE.
  - `imem_req`=0 during the reset cycle.
- Reset mid-operation aborts everything, including an outstanding request.
  - Instruction memory shares `rst` and drops in-flight requests.
  - No stale response reaches IF/ID after reset.

## Timing
- First request: `imem_req`=1 in the first cycle with `rst`=0.
- Fetch-to-IF/ID latency: with memory latency L, `valid` rises at the edge ending the `imem_rvalid` cycle, i.e. L+1 cycles after the request edge.
- Throughput without stall: one instruction per L+1 cycles. The next request is issued in the cycle after capture.
- Decode sees a captured instruction for one cycle if `stall`=0. Otherwise it is held until `stall` drops.
- After a redirect at edge E:
  - `valid`=0 from E.
  - A request to the target issues no later than 1 cycle after any discarded response returns.
- `imem_req` is never high in consecutive cycles.

## Test plan
- Reset release, L=1, memory returns 0x00500093 at 0x0, then 0x00208133 at 0x4:
  - `imem_req` at cycles 0 and 2 with addresses 0x0 and 0x4.
  - `valid`=1, `pc`=0x0, `encoding`=I_TYPE after cycle 1.
  - `pc`=0x4, `encoding`=R_TYPE after cycle 3.
- `stall`=1 for 3 cycles while a response arrives:
  - IF/ID holds the previous instruction.
  - The word is buffered in HOLD and appears on the edge after `stall` falls.
  - No `imem_req` is issued until then.
- `branch_taken`=1 with `branch_target`=0x0000_0103 while WAIT with L=3:
  - The late response is dropped and `valid`=0.
  - The next `imem_req` uses address 0x100.
  - The delivered `pc`=0x100.
- `branch_taken` and `imem_rvalid` in the same cycle with `stall`=1: word dropped, HOLD not entered, next address = target.
- `RESET_PC`=32'hFFFF_FFFC: the second request address is 0x0000_0000.
- `rst` asserted during WAIT, then a late `imem_rvalid`: outputs take their reset values, the response is ignored, and the first request uses `RESET_PC`.
